// File: rtl/nn_pkg.sv
// Shared definitions for the MNIST dense-layer sequencer.
// Holds the default layer geometry, the sequencer state encoding and the
// bit positions of the control and status registers.
package nn_pkg;

  localparam int NN_L0_NEURONS = 8;
  localparam int NN_L0_INPUTS  = 784;
  localparam int NN_L1_NEURONS = 10;
  localparam int NN_L1_INPUTS  = 8;

  // Sequencer states, kept as plain constants so older tools and the
  // existing register map tooling can consume them unchanged.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_ACCUM = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_WRITE = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Control register bits
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  // Status register bits
  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_ABORTED   = 2;
  localparam int ST_NEURON_LO = 8;
  localparam int ST_NEURON_HI = 12;
  localparam int ST_LAYER     = 16;

endpackage

// File: rtl/nn_strobe_delay.sv
// Delay line that turns the read strobe into the MAC enable strobes.
// en_in/last_in are delayed by DEPTH cycles to en_out/last_out, matching
// the weight/input memory read latency. flush clears the whole line at
// the next clock edge so no stale enable survives an abort.
// Ports: aclk, aresetn (async, active-low), flush, en_in, last_in,
//        en_out, last_out.
module nn_strobe_delay #(
  parameter int DEPTH = 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic flush,
  input  logic en_in,
  input  logic last_in,
  output logic en_out,
  output logic last_out
);

  logic [DEPTH-1:0] en_sr;
  logic [DEPTH-1:0] last_sr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_sr   <= '0;
      last_sr <= '0;
    end else if (flush) begin
      en_sr   <= '0;
      last_sr <= '0;
    end else begin
      en_sr[0]   <= en_in;
      last_sr[0] <= last_in;
      for (int k = 1; k < DEPTH; k++) begin
        en_sr[k]   <= en_sr[k-1];
        last_sr[k] <= last_sr[k-1];
      end
    end
  end

  assign en_out   = en_sr[DEPTH-1];
  assign last_out = last_sr[DEPTH-1];

endmodule

// File: rtl/nn_layer_sequencer.sv
// Two-layer dense inference sequencer (784->8->10).
// Walks every neuron of both layers: clears the accumulator with the
// neuron's bias, streams its inputs and weights, waits for the MAC
// pipeline to drain, then writes the result. Start/abort come from the
// control register; progress is reported on the status register.
// Ports:
//   aclk, aresetn      clock, async active-low reset
//   control[31:0]      [0] start (rising edge), [1] abort (level)
//   status[31:0]       [0] busy, [1] done, [2] aborted, [12:8] neuron, [16] layer
//   rd_en, wt_addr, in_addr, in_sel   weight/input memory read side
//   bias_sel, mac_clr, mac_en, mac_last  MAC datapath control
//   res_we, res_addr   result write
//   done_irq           one-cycle completion pulse
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int L0_NEURONS = NN_L0_NEURONS,
  parameter int L0_INPUTS  = NN_L0_INPUTS,
  parameter int L1_NEURONS = NN_L1_NEURONS,
  parameter int L1_INPUTS  = NN_L1_INPUTS,
  parameter int RD_LAT     = 1,
  parameter int MAC_LAT    = 2,
  parameter int WA_W       = 13
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [31:0]     control,
  output logic [31:0]     status,
  output logic            rd_en,
  output logic [WA_W-1:0] wt_addr,
  output logic [9:0]      in_addr,
  output logic            in_sel,
  output logic [4:0]      bias_sel,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            mac_last,
  output logic            res_we,
  output logic [4:0]      res_addr,
  output logic            done_irq
);

  localparam int              WT_TOTAL  = L0_NEURONS*L0_INPUTS + L1_NEURONS*L1_INPUTS;
  localparam logic [WA_W-1:0] WT_LAST   = WA_W'(WT_TOTAL - 1);
  localparam logic [9:0]      L0_LAST_I = 10'(L0_INPUTS - 1);
  localparam logic [9:0]      L1_LAST_I = 10'(L1_INPUTS - 1);
  localparam logic [4:0]      L0_LAST_N = 5'(L0_NEURONS - 1);
  localparam logic [4:0]      L1_LAST_N = 5'(L1_NEURONS - 1);
  localparam int              DR_CYC    = RD_LAT + MAC_LAT;
  localparam int              DC_W      = $clog2(DR_CYC + 1);
  localparam logic [DC_W-1:0] DR_LAST   = DC_W'(DR_CYC - 1);

  state_t          state;
  logic            start_q;
  logic            start_edge;
  logic            abort;
  logic            done_r;
  logic            aborted_r;
  logic            layer;
  logic [4:0]      neuron;
  logic [9:0]      i_cnt;
  logic [DC_W-1:0] d_cnt;
  logic [WA_W-1:0] wt_addr_r;
  logic [4:0]      gidx;
  logic            accum_last;
  logic            kill;
  logic            unused_ctrl;

  assign start_edge  = control[CTRL_START] & ~start_q;
  assign abort       = control[CTRL_ABORT];
  assign unused_ctrl = ^control[31:2];
  assign gidx        = layer ? (5'(L0_NEURONS) + neuron) : neuron;
  assign accum_last  = (state == S_ACCUM) && (i_cnt == (layer ? L1_LAST_I : L0_LAST_I));
  assign kill        = abort && (state != S_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      layer     <= 1'b0;
      neuron    <= '0;
      i_cnt     <= '0;
      d_cnt     <= '0;
      wt_addr_r <= '0;
    end else begin
      start_q <= control[CTRL_START];
      if (kill) begin
        // Abort wins over every state transition; position is dropped so
        // status reads back only the aborted flag.
        state     <= S_IDLE;
        aborted_r <= 1'b1;
        layer     <= 1'b0;
        neuron    <= '0;
        i_cnt     <= '0;
        d_cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_edge && !abort) begin
              done_r    <= 1'b0;
              aborted_r <= 1'b0;
              layer     <= 1'b0;
              neuron    <= '0;
              wt_addr_r <= '0;
              state     <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            i_cnt <= '0;
            state <= S_ACCUM;
          end
          S_ACCUM: begin
            // Weights are laid out back to back; the address holds on the
            // very last weight instead of stepping past the table.
            if (wt_addr_r != WT_LAST) wt_addr_r <= wt_addr_r + WA_W'(1);
            if (accum_last) begin
              i_cnt <= '0;
              d_cnt <= '0;
              state <= S_DRAIN;
            end else begin
              i_cnt <= i_cnt + 10'd1;
            end
          end
          S_DRAIN: begin
            if (d_cnt == DR_LAST) begin
              d_cnt <= '0;
              state <= S_WRITE;
            end else begin
              d_cnt <= d_cnt + DC_W'(1);
            end
          end
          S_WRITE: begin
            if (!layer) begin
              if (neuron == L0_LAST_N) begin
                layer  <= 1'b1;
                neuron <= '0;
              end else begin
                neuron <= neuron + 5'd1;
              end
              state <= S_CLEAR;
            end else if (neuron == L1_LAST_N) begin
              layer  <= 1'b0;
              neuron <= '0;
              state  <= S_DONE;
            end else begin
              neuron <= neuron + 5'd1;
              state  <= S_CLEAR;
            end
          end
          S_DONE: begin
            done_r <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  nn_strobe_delay #(
    .DEPTH (RD_LAT)
  ) u_strobe_delay (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .flush    (kill),
    .en_in    (rd_en),
    .last_in  (accum_last),
    .en_out   (mac_en),
    .last_out (mac_last)
  );

  assign rd_en    = (state == S_ACCUM);
  assign wt_addr  = wt_addr_r;
  assign in_addr  = rd_en ? i_cnt : '0;
  assign in_sel   = rd_en & layer;
  assign mac_clr  = (state == S_CLEAR);
  assign bias_sel = mac_clr ? gidx : '0;
  assign res_we   = (state == S_WRITE);
  assign res_addr = res_we ? gidx : '0;
  assign done_irq = (state == S_DONE);

  always_comb begin
    status                            = '0;
    status[ST_BUSY]                   = (state != S_IDLE);
    status[ST_DONE]                   = done_r;
    status[ST_ABORTED]                = aborted_r;
    status[ST_NEURON_HI:ST_NEURON_LO] = gidx;
    status[ST_LAYER]                  = layer;
  end

endmodule
